voice_allocator: RTL

- Parametrised successor to the fixed three-voice note distribution logic.
- Allocates incoming notes to NUM_VOICES external note_player instances:
  - lowest-index idle voice first;
  - oldest-voice stealing when every voice is busy.
- Mixes the per-voice samples into one registered, saturated output with active-count normalisation.
- Sits between the song reader and the bank of note_players; drives the codec sample path.

---
 rtl/voice_allocator_if.sv | 45 ++++
 rtl/voice_allocator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator_if.sv
// Voice allocator bus: song-reader request, note_player bank status/samples, allocator outputs.
// No latency of its own; pure wiring bundle.
// No backpressure; requests are single-cycle strobes.
interface voice_allocator_if #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16,
    parameter int NOTE_WIDTH   = 6,
    parameter int DUR_WIDTH    = 6
);
    localparam int ACT_W = $clog2(NUM_VOICES + 1);

    // request side (song reader)
    logic                               load_new_note;
    logic [NOTE_WIDTH-1:0]              note_to_load;
    logic [DUR_WIDTH-1:0]               duration_to_load;
    // note_player bank status and samples
    logic [NUM_VOICES-1:0]              voice_playing;
    logic [NUM_VOICES-1:0]              voice_sample_ready;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples;
    // allocator outputs
    logic [NUM_VOICES-1:0]              voice_load;
    logic [NOTE_WIDTH-1:0]              voice_note;
    logic [DUR_WIDTH-1:0]               voice_duration;
    logic [SAMPLE_WIDTH-1:0]            sample_out;
    logic                               new_sample_ready;
    logic [ACT_W-1:0]                   voices_active;
    logic                               voice_stolen;
    logic                               note_dropped;

    // environment side: drives requests and player status, observes results
    modport master (
        output load_new_note, note_to_load, duration_to_load,
        output voice_playing, voice_sample_ready, voice_samples,
        input  voice_load, voice_note, voice_duration, sample_out,
        input  new_sample_ready, voices_active, voice_stolen, note_dropped
    );

    // allocator side
    modport slave (
        input  load_new_note, note_to_load, duration_to_load,
        input  voice_playing, voice_sample_ready, voice_samples,
        output voice_load, voice_note, voice_duration, sample_out,
        output new_sample_ready, voices_active, voice_stolen, note_dropped
    );
endinterface

// File: rtl/voice_allocator.sv
// Allocates notes to NUM_VOICES note_players (lowest idle first, oldest stolen) and mixes their samples.
// Latency: 1 cycle from request/sample strobe to voice_load/new_sample_ready; all outputs registered.
// No backpressure: all-busy requests steal (VOICE_STEAL_EN defined) or are dropped (default build).
module voice_allocator #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16,
    parameter int NOTE_WIDTH   = 6,
    parameter int DUR_WIDTH    = 6
) (
    input  logic             clk,
    input  logic             reset,
    voice_allocator_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACT_W = $clog2(NUM_VOICES + 1);
    localparam int SUM_W = SAMPLE_WIDTH + $clog2(NUM_VOICES);
    localparam int EXT_W = SUM_W - SAMPLE_WIDTH;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (SAMPLE_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

    // state
    logic [NUM_VOICES-1:0]   voice_load_q, voice_load_d;
    logic [NUM_VOICES-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]        rank_q [NUM_VOICES];
    logic [IDX_W-1:0]        rank_d [NUM_VOICES];
    logic [NOTE_WIDTH-1:0]   note_q, note_d;
    logic [DUR_WIDTH-1:0]    dur_q, dur_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    nsr_q, nsr_d;
    logic [ACT_W-1:0]        active_q, active_d;
`ifdef VOICE_STEAL_EN
    logic                    stolen_q, stolen_d;
    logic [IDX_W-1:0]        oldest_idx;
`else
    logic                    dropped_q, dropped_d;
`endif

    // allocation helpers
    logic [NUM_VOICES-1:0]   busy;
    logic                    free_found;
    logic [IDX_W-1:0]        free_idx;
    logic                    take;
    logic [IDX_W-1:0]        chosen;
    logic [IDX_W-1:0]        chosen_rank;

    // mixer helpers
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    logic [SAMPLE_WIDTH-1:0] sat;
    int                      act_cnt;
    int                      shift;

    // Busy = playing or just loaded (player has not raised voice_playing yet); pick lowest free voice.
    always_comb begin
        busy       = bus.voice_playing | pending_q;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
`ifdef VOICE_STEAL_EN
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_idx = IDX_W'(i);
            end
        end
`endif
    end

    // Accept or drop the request, build the load pulse and age the ranks around the chosen voice.
    always_comb begin
        take         = 1'b0;
        chosen       = '0;
        chosen_rank  = '0;
        voice_load_d = '0;
        note_d       = note_q;
        dur_d        = dur_q;
        rank_d       = rank_q;
`ifdef VOICE_STEAL_EN
        stolen_d     = 1'b0;
`else
        dropped_d    = 1'b0;
`endif
        if (bus.load_new_note) begin
            if (free_found) begin
                take   = 1'b1;
                chosen = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                take     = 1'b1;
                chosen   = oldest_idx;
                stolen_d = 1'b1;
`else
                dropped_d = 1'b1;
`endif
            end
        end
        if (take) begin
            voice_load_d = NUM_VOICES'(1) << chosen;
            note_d       = bus.note_to_load;
            dur_d        = bus.duration_to_load;
            chosen_rank  = rank_q[chosen];
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == chosen) begin
                    rank_d[i] = '0;
                end else if (rank_q[i] < chosen_rank) begin
                    rank_d[i] = rank_q[i] + 1'b1;
                end
            end
        end
        // pending covers the load cycle and the one after it
        pending_d = voice_load_d | voice_load_q;
    end

    // Mix active voices, normalise by ceil(log2(active)) and clamp to the sample range.
    always_comb begin
        act_cnt = 0;
        sum     = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (bus.voice_playing[i]) begin
                act_cnt = act_cnt + 1;
                sum = sum + {{EXT_W{bus.voice_samples[i*SAMPLE_WIDTH + SAMPLE_WIDTH - 1]}},
                             bus.voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]};
            end
        end
        shift = 0;
        for (int k = 0; k < 4; k++) begin
            if ((1 << k) < act_cnt) begin
                shift = k + 1;
            end
        end
        shifted = sum >>> shift;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            sat = shifted[SAMPLE_WIDTH-1:0];
        end
        sample_d = sample_q;
        nsr_d    = |bus.voice_sample_ready;
        if (|bus.voice_sample_ready) begin
            sample_d = (act_cnt == 0) ? '0 : sat;
        end
        active_d = ACT_W'(act_cnt);
    end

    // State registers with synchronous reset; ranks restart as the identity permutation.
    always_ff @(posedge clk) begin
        if (reset) begin
            voice_load_q <= '0;
            pending_q    <= '0;
            note_q       <= '0;
            dur_q        <= '0;
            sample_q     <= '0;
            nsr_q        <= 1'b0;
            active_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= IDX_W'(i);
            end
`ifdef VOICE_STEAL_EN
            stolen_q     <= 1'b0;
`else
            dropped_q    <= 1'b0;
`endif
        end else begin
            voice_load_q <= voice_load_d;
            pending_q    <= pending_d;
            note_q       <= note_d;
            dur_q        <= dur_d;
            sample_q     <= sample_d;
            nsr_q        <= nsr_d;
            active_q     <= active_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= rank_d[i];
            end
`ifdef VOICE_STEAL_EN
            stolen_q     <= stolen_d;
`else
            dropped_q    <= dropped_d;
`endif
        end
    end

    // Outputs read as zero while reset is high, so a pulse already queued is cancelled.
    assign bus.voice_load       = reset ? '0   : voice_load_q;
    assign bus.voice_note       = reset ? '0   : note_q;
    assign bus.voice_duration   = reset ? '0   : dur_q;
    assign bus.sample_out       = reset ? '0   : sample_q;
    assign bus.new_sample_ready = reset ? 1'b0 : nsr_q;
    assign bus.voices_active    = reset ? '0   : active_q;
`ifdef VOICE_STEAL_EN
    assign bus.voice_stolen     = reset ? 1'b0 : stolen_q;
    assign bus.note_dropped     = 1'b0;
`else
    assign bus.voice_stolen     = 1'b0;
    assign bus.note_dropped     = reset ? 1'b0 : dropped_q;
`endif
endmodule
